dm_arbiter: RTL and testbench
=============================

# dm_arbiter

Shares the single data-memory port (DM_4K) between the single-cycle CPU206 datapath and a debug/loader burst port. The CPU keeps a zero-latency combinational path; the debug port gets bounded-wait access through word bursts. While a burst runs, the CPU sees a stall that freezes PC and register writeback. Sits in DataPath between the ALU/regfile memory signals and DM_4K.

## Interface
- ADDR_W, 12, byte address width (4 KB).
- DATA_W, 32, word width.
- MAX_WAIT, 4, max cycles a pending debug request waits while the CPU is busy.
- BURST_MAX, 8, max words per debug burst.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- cpu_req / cpu_we  in  1  CPU memory access / write.
- cpu_be  in  4  CPU byte enables.
- cpu_addr  in  ADDR_W  CPU byte address.
- cpu_wdata  in  DATA_W  CPU write data.
- cpu_rdata  out  DATA_W  equals mem_rdata.
- cpu_stall  out  1  CPU must hold its state this cycle.
- dbg_req / dbg_we  in  1  burst request (held until dbg_done) / burst is write.
- dbg_addr  in  ADDR_W  burst base; bits [1:0] ignored.
- dbg_len  in  4  words, 1..BURST_MAX; 0 treated as 1, >BURST_MAX clamped.
- dbg_wdata  in  DATA_W  write data for the current beat.
- dbg_wready  out  1  dbg_wdata consumed this cycle.
- dbg_rdata  out  DATA_W  registered read beat.
- dbg_rvalid / dbg_done  out  1  read beat valid / one-cycle burst-complete pulse.
- mem_en, mem_we  out  1; mem_be  out  4; mem_addr  out  ADDR_W; mem_wdata  out  DATA_W  to DM_4K.
- mem_rdata  in  DATA_W  combinational DM_4K read data.

## Operation
- Two states: S_CPU (reset) and S_DBG.
- S_CPU: mem_* = cpu_* gated by cpu_req; mem_en = cpu_req; cpu_stall = 0.
- wait_cnt: counts cycles in S_CPU with dbg_req && cpu_req. It clears when dbg_req is low or on entry to S_DBG, and saturates at MAX_WAIT-1.
- S_CPU -> S_DBG at the clock edge when dbg_req && (!cpu_req || wait_cnt == MAX_WAIT-1).
- On entry, latch base = {dbg_addr[ADDR_W-1:2], 2'b00}, len (after clamp/zero rule) and we. Clear beat counter.
- S_DBG, one beat per cycle:
  - mem_en = 1, mem_be = 4'hF, mem_we = latched we, mem_addr = base + 4*beat, wrapping modulo 2^ADDR_W.
  - cpu_stall = cpu_req; CPU memory signals are ignored.
  - Write burst: dbg_wready = 1 each beat and mem_wdata = dbg_wdata.
  - Read burst: dbg_rdata <= mem_rdata and dbg_rvalid <= 1 at the end of each beat.
- After the last beat, the edge returns the state to S_CPU and pulses dbg_done for one cycle.
- Fairness: after a burst, a new burst cannot start while cpu_req has been high for fewer than MAX_WAIT cycles in S_CPU (wait_cnt rule), so the CPU always gets at least MAX_WAIT-1 cycles between bursts.
- dbg_req dropping mid-burst is ignored; the burst completes.
- A dbg_req still high in the dbg_done cycle starts a new burst only under the entry rule.

## Timing
- CPU path: zero-latency combinational, no added cycles when not stalled.
- Debug request accepted at edge E: beats in cycles E..E+len-1.
  - Write data is consumed in those cycles.
  - Read data (dbg_rvalid) appears in cycles E+1..E+len.
  - dbg_done fires in cycle E+len, coincident with the last dbg_rvalid for reads.
- Worst-case debug wait: MAX_WAIT cycles. Worst-case CPU stall: BURST_MAX consecutive cycles.
- Reset values: state S_CPU, wait_cnt 0, beat 0, dbg_rvalid 0, dbg_done 0, dbg_rdata 0. Combinational outputs follow S_CPU: cpu_stall 0, dbg_wready 0.
- Reset mid-burst: abort immediately with no dbg_done. Beats already written remain in memory.

## Structure
- Package dm_arb_pkg: state enum {S_CPU, S_DBG}, WORD_BYTES = 4, default ADDR_W/DATA_W/BURST_MAX, length clamp function.
- Sub-module dbg_burst_ctr: latches base and len, generates beat address with wrap, flags the last beat.
- The state machine, wait counter and output muxing live in dm_arbiter.

## Test plan
- cpu_req = 0, dbg write burst addr 0x014, len 2, data 0xAAAA5555 / 0x12345678 -> 0x014 and 0x018 hold those words; dbg_done in cycle E+2; cpu_stall never high.
- cpu_req held high, dbg_req raised -> burst starts at the 4th cycle (MAX_WAIT = 4); cpu_stall high for exactly len cycles; CPU accesses before the burst reach memory unchanged.
- Read burst addr 0xFFC, len 3 -> reads 0xFFC, 0x000, 0x004 (wrap); three dbg_rvalid pulses with the matching data.
- dbg_len = 0 -> one beat; dbg_len = 15 -> eight beats (clamp).
- rst low during beat 1 of a 4-word write -> only beat 0 written, no dbg_done, state S_CPU, cpu_stall 0.
- dbg_req held through dbg_done with cpu_req high -> next burst delayed ≥ MAX_WAIT-1 cycles; CPU sw to 0x01C in that gap lands in memory.

Source files
------------

// File: rtl/dm_arb_pkg.sv
// Shared types and helpers for the DM_4K port arbiter.
package dm_arb_pkg;
  typedef enum logic {S_CPU = 1'b0, S_DBG = 1'b1} state_e;

  localparam int WORD_BYTES    = 4;
  localparam int LEN_W         = 4;
  localparam int ADDR_W_DEF    = 12;
  localparam int DATA_W_DEF    = 32;
  localparam int BURST_MAX_DEF = 8;
  localparam int MAX_WAIT_DEF  = 4;

  // Zero-length bursts run one beat; oversize bursts are cut to bmax.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len,
                                                 input logic [LEN_W-1:0] bmax);
    if (len == '0) return LEN_W'(1);
    if (len > bmax) return bmax;
    return len;
  endfunction
endpackage

// File: rtl/dbg_burst_ctr.sv
// Debug burst sequencer: latches base/length, walks word addresses with wrap.
module dbg_burst_ctr import dm_arb_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_load,
  input  logic              i_adv,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_len,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_last
);
  logic [ADDR_W-1:0] r_base;
  logic [LEN_W-1:0]  r_len;
  logic [LEN_W-1:0]  r_beat;
  logic              w_unused_lo;

  assign w_unused_lo = &{1'b0, i_addr[1:0]};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_base <= '0;
      r_len  <= LEN_W'(1);
      r_beat <= '0;
    end else if (i_load) begin
      r_base <= {i_addr[ADDR_W-1:2], 2'b00};
      r_len  <= clamp_len(i_len, LEN_W'(BURST_MAX));
      r_beat <= '0;
    end else if (i_adv) begin
      r_beat <= r_beat + LEN_W'(1);
    end
  end

  // Sum truncates to ADDR_W, so bursts wrap around the top of memory.
  assign o_addr = r_base + ADDR_W'(r_beat) * ADDR_W'(WORD_BYTES);
  assign o_last = (r_beat == r_len - LEN_W'(1));
endmodule

// File: rtl/dm_arbiter.sv
// Shares the DM_4K port between the zero-latency CPU path and debug word bursts.
module dm_arbiter import dm_arb_pkg::*; #(
  parameter int ADDR_W    = ADDR_W_DEF,
  parameter int DATA_W    = DATA_W_DEF,
  parameter int MAX_WAIT  = MAX_WAIT_DEF,
  parameter int BURST_MAX = BURST_MAX_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_cpu_req,
  input  logic              i_cpu_we,
  input  logic [3:0]        i_cpu_be,
  input  logic [ADDR_W-1:0] i_cpu_addr,
  input  logic [DATA_W-1:0] i_cpu_wdata,
  output logic [DATA_W-1:0] o_cpu_rdata,
  output logic              o_cpu_stall,
  input  logic              i_dbg_req,
  input  logic              i_dbg_we,
  input  logic [ADDR_W-1:0] i_dbg_addr,
  input  logic [LEN_W-1:0]  i_dbg_len,
  input  logic [DATA_W-1:0] i_dbg_wdata,
  output logic              o_dbg_wready,
  output logic [DATA_W-1:0] o_dbg_rdata,
  output logic              o_dbg_rvalid,
  output logic              o_dbg_done,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [3:0]        o_mem_be,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata
);
  localparam int WCW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [WCW-1:0] WAIT_TOP = WCW'(MAX_WAIT - 1);

  state_e            r_state, w_next;
  logic [WCW-1:0]    r_wait;
  logic              r_we;
  logic              r_rvalid, r_done;
  logic [DATA_W-1:0] r_rdata;
  logic              w_start, w_beat, w_last;
  logic [ADDR_W-1:0] w_beat_addr;

  // A waiting burst may only steal the port once the CPU has had its share.
  assign w_start = (r_state == S_CPU) && i_dbg_req &&
                   (!i_cpu_req || (r_wait == WAIT_TOP));
  assign w_beat  = (r_state == S_DBG);

  dbg_burst_ctr #(.ADDR_W(ADDR_W), .BURST_MAX(BURST_MAX)) u_ctr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_load  (w_start),
    .i_adv   (w_beat),
    .i_addr  (i_dbg_addr),
    .i_len   (i_dbg_len),
    .o_addr  (w_beat_addr),
    .o_last  (w_last)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= S_CPU;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    o_mem_en     = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_be     = 4'h0;
    o_mem_addr   = '0;
    o_mem_wdata  = '0;
    o_cpu_stall  = 1'b0;
    o_dbg_wready = 1'b0;
    case (r_state)
      S_CPU: begin
        o_mem_en = i_cpu_req;
        o_mem_we = i_cpu_req & i_cpu_we;
        if (i_cpu_req) begin
          o_mem_be    = i_cpu_be;
          o_mem_addr  = i_cpu_addr;
          o_mem_wdata = i_cpu_wdata;
        end
        if (w_start) w_next = S_DBG;
      end
      S_DBG: begin
        o_mem_en    = 1'b1;
        o_mem_we    = r_we;
        o_mem_be    = 4'hF;
        o_mem_addr  = w_beat_addr;
        o_cpu_stall = i_cpu_req;
        if (r_we) begin
          o_dbg_wready = 1'b1;
          o_mem_wdata  = i_dbg_wdata;
        end
        if (w_last) w_next = S_CPU;
      end
      default: w_next = S_CPU;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wait <= '0;
    end else if (!i_dbg_req || w_start || w_beat) begin
      r_wait <= '0;
    end else if (i_cpu_req && (r_wait != WAIT_TOP)) begin
      r_wait <= r_wait + WCW'(1);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_we     <= 1'b0;
      r_rvalid <= 1'b0;
      r_done   <= 1'b0;
      r_rdata  <= '0;
    end else begin
      if (w_start) r_we <= i_dbg_we;
      r_rvalid <= w_beat && !r_we;
      r_done   <= w_beat && w_last;
      if (w_beat && !r_we) r_rdata <= i_mem_rdata;
    end
  end

  assign o_cpu_rdata  = i_mem_rdata;
  assign o_dbg_rdata  = r_rdata;
  assign o_dbg_rvalid = r_rvalid;
  assign o_dbg_done   = r_done;
endmodule

// File: tb/tb_dm_arbiter.sv
// Scenario bench for dm_arbiter with a DM_4K model and write/read scoreboards.
module tb_dm_arbiter;
  localparam int MW = 4;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic        cpu_req, cpu_we, dbg_req, dbg_we;
  logic [3:0]  cpu_be, dbg_len;
  logic [11:0] cpu_addr, dbg_addr;
  logic [31:0] cpu_wdata, dbg_wdata;
  logic [31:0] cpu_rdata, dbg_rdata, mem_rdata, mem_wdata;
  logic        cpu_stall, dbg_wready, dbg_rvalid, dbg_done, mem_en, mem_we;
  logic [3:0]  mem_be;
  logic [11:0] mem_addr;

  dm_arbiter #(.ADDR_W(12), .DATA_W(32), .MAX_WAIT(MW), .BURST_MAX(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cpu_req(cpu_req), .i_cpu_we(cpu_we), .i_cpu_be(cpu_be), .i_cpu_addr(cpu_addr),
    .i_cpu_wdata(cpu_wdata), .o_cpu_rdata(cpu_rdata), .o_cpu_stall(cpu_stall),
    .i_dbg_req(dbg_req), .i_dbg_we(dbg_we), .i_dbg_addr(dbg_addr), .i_dbg_len(dbg_len),
    .i_dbg_wdata(dbg_wdata), .o_dbg_wready(dbg_wready), .o_dbg_rdata(dbg_rdata),
    .o_dbg_rvalid(dbg_rvalid), .o_dbg_done(dbg_done),
    .o_mem_en(mem_en), .o_mem_we(mem_we), .o_mem_be(mem_be), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  bit [31:0] mem [1024];
  bit [31:0] exp_mem [1024];
  assign mem_rdata = mem[mem_addr[11:2]];
  always @(posedge clk)
    if (mem_en && mem_we)
      for (int b = 0; b < 4; b++)
        if (mem_be[b]) mem[mem_addr[11:2]][8*b +: 8] <= mem_wdata[8*b +: 8];

  typedef struct { logic [11:0] addr; logic [31:0] data; logic [3:0] be; } wr_t;
  wr_t         wr_q [$];
  logic [31:0] rd_q [$];
  wr_t         me;
  logic [31:0] re;
  int          n_checks = 0, n_errors = 0, n_rvalid = 0;
  bit          stall_seen = 0;

  // Scoreboard: every memory write and every read beat must match the next expectation.
  always @(negedge clk) begin
    if (cpu_stall) stall_seen = 1;
    if (rst_n && mem_en && mem_we) begin
      n_checks++;
      if (wr_q.size() == 0) begin
        n_errors++;
        $display("FAIL mem_write unexpected: addr=%h data=%h", mem_addr, mem_wdata);
      end else begin
        me = wr_q.pop_front();
        if (mem_addr !== me.addr || mem_wdata !== me.data || mem_be !== me.be) begin
          n_errors++;
          $display("FAIL mem_write: got addr=%h data=%h be=%h, exp addr=%h data=%h be=%h",
                   mem_addr, mem_wdata, mem_be, me.addr, me.data, me.be);
        end
      end
    end
    if (dbg_rvalid) begin
      n_rvalid++;
      n_checks++;
      if (rd_q.size() == 0) begin
        n_errors++;
        $display("FAIL dbg_rdata unexpected beat: got %h", dbg_rdata);
      end else begin
        re = rd_q.pop_front();
        if (dbg_rdata !== re) begin
          n_errors++;
          $display("FAIL dbg_rdata: got %h exp %h", dbg_rdata, re);
        end
      end
    end
  end

  task automatic step(); @(posedge clk); #1; endtask
  task automatic sample(); @(negedge clk); endtask

  task automatic idle();
    cpu_req = 0; cpu_we = 0; cpu_be = 4'h0; cpu_addr = '0; cpu_wdata = '0;
    dbg_req = 0; dbg_we = 0; dbg_addr = '0; dbg_len = '0; dbg_wdata = '0;
  endtask

  task automatic push_wr(input logic [11:0] a, input logic [31:0] d, input logic [3:0] be);
    wr_t e;
    e.addr = a; e.data = d; e.be = be;
    wr_q.push_back(e);
    for (int b = 0; b < 4; b++) if (be[b]) exp_mem[a[11:2]][8*b +: 8] = d[8*b +: 8];
  endtask

  task automatic cpu_write(input logic [11:0] a, input logic [31:0] d);
    cpu_req = 1; cpu_we = 1; cpu_be = 4'hF; cpu_addr = a; cpu_wdata = d;
    push_wr(a, d, 4'hF);
    step();
    cpu_req = 0; cpu_we = 0;
  endtask

  task automatic test_reset();
    idle();
    cpu_req = 1; cpu_addr = 12'h010;
    sample();
    n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL reset_stall got %b exp 0", cpu_stall); end
    n_checks++; if (dbg_wready !== 1'b0) begin n_errors++; $display("FAIL reset_wready got %b exp 0", dbg_wready); end
    n_checks++; if (dbg_rvalid !== 1'b0) begin n_errors++; $display("FAIL reset_rvalid got %b exp 0", dbg_rvalid); end
    n_checks++; if (dbg_done !== 1'b0) begin n_errors++; $display("FAIL reset_done got %b exp 0", dbg_done); end
    n_checks++; if (dbg_rdata !== 32'h0) begin n_errors++; $display("FAIL reset_rdata got %h exp 0", dbg_rdata); end
    n_checks++; if (mem_addr !== 12'h010 || mem_en !== 1'b1) begin n_errors++; $display("FAIL reset_cpu_path got en=%b addr=%h exp en=1 addr=010", mem_en, mem_addr); end
    step();
    rst_n = 1; idle();
    step();
  endtask

  task automatic test_dbg_write();
    stall_seen = 0;
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h014; dbg_len = 4'd2; dbg_wdata = 32'hAAAA5555;
    step();
    push_wr(12'h014, 32'hAAAA5555, 4'hF);
    sample();
    n_checks++; if (dbg_wready !== 1'b1 || mem_addr !== 12'h014) begin n_errors++; $display("FAIL wr_beat0 got wready=%b addr=%h exp 1/014", dbg_wready, mem_addr); end
    step();
    dbg_req = 0; dbg_wdata = 32'h12345678;
    push_wr(12'h018, 32'h12345678, 4'hF);
    sample();
    n_checks++; if (mem_addr !== 12'h018 || dbg_done !== 1'b0) begin n_errors++; $display("FAIL wr_beat1 got addr=%h done=%b exp 018/0", mem_addr, dbg_done); end
    step();
    sample();
    n_checks++; if (dbg_done !== 1'b1 || dbg_wready !== 1'b0) begin n_errors++; $display("FAIL wr_done got done=%b wready=%b exp 1/0", dbg_done, dbg_wready); end
    step();
    sample();
    n_checks++; if (dbg_done !== 1'b0) begin n_errors++; $display("FAIL wr_done_pulse got %b exp 0", dbg_done); end
    n_checks++; if (mem[5] !== 32'hAAAA5555 || mem[6] !== 32'h12345678) begin n_errors++; $display("FAIL wr_mem got %h %h exp aaaa5555 12345678", mem[5], mem[6]); end
    n_checks++; if (stall_seen !== 1'b0) begin n_errors++; $display("FAIL wr_no_stall got 1 exp 0"); end
    step();
  endtask

  task automatic test_cpu_wait();
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h100; dbg_len = 4'd2; dbg_wdata = 32'hD0D0_0000;
    for (int k = 0; k < MW; k++) begin
      cpu_req = 1; cpu_we = 1; cpu_be = 4'hF;
      cpu_addr = 12'h040 + 12'(4*k); cpu_wdata = 32'hC0DE_0000 + 32'(k);
      push_wr(cpu_addr, cpu_wdata, 4'hF);
      sample();
      n_checks++; if (cpu_stall !== 1'b0) begin n_errors++; $display("FAIL wait_stall cycle %0d got 1 exp 0", k); end
      step();
    end
    for (int b = 0; b < 2; b++) begin
      cpu_addr = 12'h060; cpu_wdata = 32'hDEAD_DEAD;
      dbg_wdata = 32'hD0D0_0000 + 32'(b);
      push_wr(12'h100 + 12'(4*b), dbg_wdata, 4'hF);
      sample();
      n_checks++; if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL burst_stall beat %0d got 0 exp 1", b); end
      step();
    end
    dbg_req = 0; cpu_addr = 12'h060; cpu_wdata = 32'h5A5A_5A5A;
    push_wr(12'h060, 32'h5A5A_5A5A, 4'hF);
    sample();
    n_checks++; if (dbg_done !== 1'b1 || cpu_stall !== 1'b0) begin n_errors++; $display("FAIL wait_done got done=%b stall=%b exp 1/0", dbg_done, cpu_stall); end
    step();
    idle();
    step();
  endtask

  task automatic test_read_wrap();
    logic [11:0] wa [3];
    wa = '{12'hFFC, 12'h000, 12'h004};
    cpu_write(12'hFFC, 32'h1111_0FFC);
    cpu_write(12'h000, 32'h2222_0000);
    cpu_write(12'h004, 32'h3333_0004);
    idle();
    for (int b = 0; b < 3; b++) rd_q.push_back(exp_mem[wa[b][11:2]]);
    n_rvalid = 0;
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'hFFD; dbg_len = 4'd3;
    step();
    dbg_req = 0;
    for (int b = 0; b < 3; b++) begin
      sample();
      n_checks++; if (mem_addr !== wa[b] || mem_we !== 1'b0) begin n_errors++; $display("FAIL rd_addr beat %0d got %h we=%b exp %h we=0", b, mem_addr, mem_we, wa[b]); end
      step();
    end
    sample();
    n_checks++; if (dbg_done !== 1'b1 || dbg_rvalid !== 1'b1) begin n_errors++; $display("FAIL rd_done got done=%b rvalid=%b exp 1/1", dbg_done, dbg_rvalid); end
    step();
    sample();
    n_checks++; if (n_rvalid !== 3 || rd_q.size() !== 0) begin n_errors++; $display("FAIL rd_count got %0d beats (%0d left) exp 3 (0)", n_rvalid, rd_q.size()); end
    step();
  endtask

  task automatic test_len_clamp();
    logic [11:0] bases [2];
    logic [3:0]  lens  [2];
    int          nb    [2];
    int          beats;
    bit          got_done;
    bases = '{12'h200, 12'h300}; lens = '{4'd0, 4'd15}; nb = '{1, 8};
    cpu_write(12'h200, 32'h0200_ABCD);
    for (int i = 0; i < 9; i++) cpu_write(12'h300 + 12'(4*i), 32'h0300_0000 + 32'(i));
    idle();
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < nb[r]; i++) rd_q.push_back(exp_mem[bases[r][11:2] + 10'(i)]);
      dbg_req = 1; dbg_we = 0; dbg_addr = bases[r]; dbg_len = lens[r];
      step();
      dbg_req = 0;
      beats = 0; got_done = 0;
      for (int t = 0; t < 20 && !got_done; t++) begin
        sample();
        if (mem_en) beats++;
        if (dbg_done) got_done = 1;
        step();
      end
      n_checks++; if (!got_done) begin n_errors++; $display("FAIL clamp_timeout len=%0d got no done exp done", lens[r]); end
      n_checks++; if (beats !== nb[r]) begin n_errors++; $display("FAIL clamp_beats len=%0d got %0d exp %0d", lens[r], beats, nb[r]); end
    end
    n_checks++; if (rd_q.size() !== 0) begin n_errors++; $display("FAIL clamp_reads got %0d pending exp 0", rd_q.size()); end
  endtask

  task automatic test_reset_mid();
    bit done_seen;
    idle();
    dbg_req = 1; dbg_we = 1; dbg_addr = 12'h080; dbg_len = 4'd4; dbg_wdata = 32'hBEEF_0000;
    step();
    push_wr(12'h080, 32'hBEEF_0000, 4'hF);
    sample();
    step();
    dbg_wdata = 32'hBEEF_0001; dbg_req = 0;
    cpu_req = 1; cpu_we = 0; cpu_addr = 12'h024;
    rst_n = 0;
    sample();
    n_checks++; if (cpu_stall !== 1'b0 || dbg_wready !== 1'b0) begin n_errors++; $display("FAIL rstmid_outputs got stall=%b wready=%b exp 0/0", cpu_stall, dbg_wready); end
    n_checks++; if (mem_we !== 1'b0 || mem_addr !== 12'h024) begin n_errors++; $display("FAIL rstmid_cpu_path got we=%b addr=%h exp 0/024", mem_we, mem_addr); end
    step();
    rst_n = 1; idle();
    done_seen = 0;
    for (int t = 0; t < 5; t++) begin
      sample();
      if (dbg_done) done_seen = 1;
      step();
    end
    n_checks++; if (done_seen) begin n_errors++; $display("FAIL rstmid_done got 1 exp 0"); end
    n_checks++; if (mem[32] !== 32'hBEEF_0000 || mem[33] !== exp_mem[33]) begin n_errors++; $display("FAIL rstmid_mem got %h %h exp beef0000 %h", mem[32], mem[33], exp_mem[33]); end
  endtask

  task automatic test_back_to_back();
    int gap;
    bit hit;
    cpu_write(12'h240, 32'h7777_0240);
    idle();
    rd_q.push_back(exp_mem[10'h90]);
    rd_q.push_back(exp_mem[10'h90]);
    dbg_req = 1; dbg_we = 0; dbg_addr = 12'h240; dbg_len = 4'd1;
    step();
    cpu_req = 1; cpu_we = 0; cpu_be = 4'hF; cpu_addr = 12'h000;
    sample();
    n_checks++; if (cpu_stall !== 1'b1) begin n_errors++; $display("FAIL b2b_stall1 got 0 exp 1"); end
    step();
    cpu_we = 1; cpu_addr = 12'h01C; cpu_wdata = 32'h0BAD_F00D;
    push_wr(12'h01C, 32'h0BAD_F00D, 4'hF);
    sample();
    n_checks++; if (dbg_done !== 1'b1 || cpu_stall !== 1'b0) begin n_errors++; $display("FAIL b2b_done1 got done=%b stall=%b exp 1/0", dbg_done, cpu_stall); end
    gap = 1; hit = 0;
    step();
    cpu_we = 0; cpu_addr = 12'h000;
    for (int t = 0; t < 20 && !hit; t++) begin
      sample();
      if (cpu_stall) hit = 1;
      else begin gap++; step(); end
    end
    dbg_req = 0;
    n_checks++; if (!hit) begin n_errors++; $display("FAIL b2b_timeout got no second burst exp one"); end
    n_checks++; if (gap !== MW) begin n_errors++; $display("FAIL b2b_gap got %0d cpu cycles exp %0d", gap, MW); end
    step();
    sample();
    n_checks++; if (dbg_done !== 1'b1) begin n_errors++; $display("FAIL b2b_done2 got 0 exp 1"); end
    step();
    idle();
    sample();
    n_checks++; if (mem[7] !== 32'h0BAD_F00D) begin n_errors++; $display("FAIL b2b_cpu_sw got %h exp 0badf00d", mem[7]); end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_dbg_write();
    test_cpu_wait();
    test_read_wrap();
    test_len_clamp();
    test_reset_mid();
    test_back_to_back();
    n_checks++;
    if (wr_q.size() !== 0 || rd_q.size() !== 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain got wr=%0d rd=%0d pending exp 0/0", wr_q.size(), rd_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
